gate_pair_tester: RTL and testbench

Clocked stimulus and capture stage wrapped around the two-input gate pair (a = ~x | y, b = x | y). On a start request it drives x/y through all four input combinations, waits a programmable settle time, samples both gate outputs, and compares them against the expected values. It reports a packed result word, a mismatch count and a pass flag. It replaces the hand-written `#1` stimulus sequence with a repeatable, self-checking hardware sequencer.

---
 rtl/gate_pair_tester.sv | 94 +++++++++
 tb/tb_gate_pair_tester.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_pair_tester.sv
// Sequencer that drives the (a = ~x | y, b = x | y) gate pair through all four
// input vectors, samples each after a settle window and scores the responses.
module gate_pair_tester #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       a,
  input  logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [7:0] result
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic {
    IDLE,
    APPLY
  } state_t;

  state_t     state;
  logic [1:0] vec;
  logic [1:0] vec_next;
  logic [3:0] cnt;
  logic       miss;
  logic [2:0] err_next;

  // A vector with both outputs wrong still counts as a single mismatch.
  always_comb begin
    miss     = (a != (~x | y)) || (b != (x | y));
    err_next = err_count + {2'b00, miss};
    vec_next = vec + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= APPLY;
            vec       <= '0;
            cnt       <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            result    <= '0;
          end
        end
        APPLY: begin
          // The load edge counts as the first of the SETTLE+1 hold cycles.
          if (cnt == SETTLE_CNT) begin
            cnt                     <= '0;
            result[{vec, 1'b0} +: 2] <= {a, b};
            err_count               <= err_next;
            if (vec == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
            end else begin
              vec <= vec_next;
              x   <= vec_next[1];
              y   <= vec_next[0];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_pair_tester.sv
// Bench for gate_pair_tester: SETTLE=1 and SETTLE=0 instances against a
// cycle-count model, plus directed runs with hand-computed results.
module tb_gate_pair_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  int         fault0;
  logic       x0, y0, a0, b0, busy0, done0, pass0;
  logic       x1, y1, a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [7:0] res0, res1;
  int         checks = 0;
  int         errors = 0;
  logic       armed = 1'b0;

  always #5 clk = ~clk;

  // Gate model: 0 = healthy, 1 = b stuck at 0, 2 = both outputs inverted.
  function automatic logic [1:0] gate(input logic gx, input logic gy, input int f);
    logic ea, eb;
    ea = ~gx | gy;
    eb = gx | gy;
    case (f)
      1:       return {ea, 1'b0};
      2:       return {~ea, ~eb};
      default: return {ea, eb};
    endcase
  endfunction

  assign {a0, b0} = gate(x0, y0, fault0);
  assign {a1, b1} = gate(x1, y1, 0);

  gate_pair_tester #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .y(y0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .result(res0)
  );

  gate_pair_tester #(.SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .y(y1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .result(res1)
  );

  typedef struct {
    logic       active;
    int         t;
    logic       x, y, busy, done, pass;
    int         err;
    logic [7:0] result;
  } model_t;

  model_t m[2];

  // Model: cycles since the start edge; sample k lands at t = (k+1)*period.
  always @(posedge clk) begin
    model_t     n;
    int         p, k, f;
    logic       st;
    logic [1:0] got, want;
    for (int i = 0; i < 2; i++) begin
      n  = m[i];
      p  = (i == 0) ? 2 : 1;
      st = (i == 0) ? start0 : start1;
      f  = (i == 0) ? fault0 : 0;
      if (!rst_n) begin
        n.active = 1'b0; n.t = 0; n.x = 1'b0; n.y = 1'b0; n.busy = 1'b0;
        n.done = 1'b0; n.pass = 1'b0; n.err = 0; n.result = 8'h00;
      end else begin
        n.done = 1'b0;
        if (!n.active) begin
          if (st) begin
            n.active = 1'b1; n.t = 0; n.err = 0; n.result = 8'h00;
            n.pass = 1'b0; n.busy = 1'b1; n.x = 1'b0; n.y = 1'b0;
          end
        end else begin
          n.t = n.t + 1;
          if (n.t % p == 0) begin
            k    = n.t / p - 1;
            got  = gate(n.x, n.y, f);
            want = gate(n.x, n.y, 0);
            n.result[2*k +: 2] = got;
            if (got != want) n.err = n.err + 1;
            if (k == 3) begin
              n.active = 1'b0; n.busy = 1'b0; n.done = 1'b1; n.pass = (n.err == 0);
            end else begin
              n.x = ((k + 1) >= 2);
              n.y = ((k + 1) % 2 == 1);
            end
          end
        end
      end
      m[i] <= n;
    end
  end

  task automatic check_vec(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare of {x,y,busy,done,pass,err_count,result}.
  always @(negedge clk) begin
    if (armed) begin
      check_vec("cycle_settle1", {x0, y0, busy0, done0, pass0, err0, res0},
                {m[0].x, m[0].y, m[0].busy, m[0].done, m[0].pass, 3'(m[0].err), m[0].result});
      check_vec("cycle_settle0", {x1, y1, busy1, done1, pass1, err1, res1},
                {m[1].x, m[1].y, m[1].busy, m[1].done, m[1].pass, 3'(m[1].err), m[1].result});
    end
  end

  // Raises start at a negedge, holds it for `hold` cycles and returns in the
  // done cycle; lat counts negedges from the start edge (done at E8 -> 9).
  task automatic do_run(input int inst, input int hold, output int lat);
    int c;
    c = 0;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    forever begin
      @(negedge clk);
      c++;
      if (c >= hold) begin
        if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
      end
      if ((inst == 0 && done0) || (inst == 1 && done1)) break;
      if (c > 40) begin
        checks++;
        errors++;
        $display("FAIL done_timeout inst %0d got no done expected done within 40 cycles", inst);
        start0 = 1'b0;
        start1 = 1'b0;
        break;
      end
    end
    lat = c;
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fault0 = 0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    check_vec("reset_state", {x0, y0, busy0, done0, pass0, err0, res0}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Healthy gates, SETTLE=1.
    do_run(0, 1, lat);
    check_vec("lat_good", 16'(lat), 16'd9);
    check_vec("good_res", {5'b0, pass0, err0, res0}, {5'b0, 1'b1, 3'd0, 8'hDE});
    @(negedge clk);
    check_vec("idle_xy_hold", {14'b0, x0, y0}, 16'h0003);

    // b stuck at 0.
    fault0 = 1;
    do_run(0, 1, lat);
    check_vec("stuck_res", {5'b0, pass0, err0, res0}, {5'b0, 1'b0, 3'd3, 8'h8A});
    repeat (3) @(negedge clk);
    check_vec("stuck_hold", {5'b0, pass0, err0, res0}, {5'b0, 1'b0, 3'd3, 8'h8A});

    // Both outputs inverted: every vector fails once.
    fault0 = 2;
    do_run(0, 1, lat);
    check_vec("invert_res", {5'b0, pass0, err0, res0}, {5'b0, 1'b0, 3'd4, 8'h21});
    fault0 = 0;
    @(negedge clk);

    // Reset at E3 of a run.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_vec("midrun_reset", {x0, y0, busy0, done0, pass0, err0, res0}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // start held through E7: exactly one run, done at E8.
    do_run(0, 8, lat);
    check_vec("lat_held", 16'(lat), 16'd9);
    // Back-to-back: start in the done cycle.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check_vec("b2b_clear", {busy0, done0, 3'b0, err0, res0}, {1'b1, 1'b0, 3'b0, 3'd0, 8'h00});
    lat = 1;
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_vec("lat_b2b", 16'(lat), 16'd9);
    check_vec("b2b_res", {5'b0, pass0, err0, res0}, {5'b0, 1'b1, 3'd0, 8'hDE});
    @(negedge clk);
    check_vec("no_rerun", {15'b0, busy0}, 16'h0000);

    // SETTLE=0 instance.
    do_run(1, 1, lat);
    check_vec("lat_settle0", 16'(lat), 16'd5);
    check_vec("settle0_res", {5'b0, pass1, err1, res1}, {5'b0, 1'b1, 3'd0, 8'hDE});
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
